// File: rtl/evo_test_sequencer_if.sv
// rtl/evo_test_sequencer_if.sv - host/circuit-side signal bundle for the truth-table sequencer
interface evo_test_sequencer_if #(
  parameter int NUM_INPUTS = 5
);
  localparam int NV = 1 << NUM_INPUTS;

  logic                  start;
  logic                  abort;
  logic [NV-1:0]         expected;
  logic [NUM_INPUTS-1:0] dut_in;
  logic                  dut_out;
  logic                  busy;
  logic                  done;
  logic                  pass;
  logic [NUM_INPUTS:0]   mismatch_count;
  logic [NUM_INPUTS:0]   unstable_count;
  logic [NV-1:0]         result_vec;

  modport master (
    output start, abort, expected, dut_out,
    input  dut_in, busy, done, pass, mismatch_count, unstable_count, result_vec
  );

  modport slave (
    input  start, abort, expected, dut_out,
    output dut_in, busy, done, pass, mismatch_count, unstable_count, result_vec
  );
endinterface

// File: rtl/evo_test_sequencer.sv
// rtl/evo_test_sequencer.sv - exhaustive truth-table sequencer for one evolved N-input circuit
module evo_test_sequencer #(
  parameter int NUM_INPUTS    = 5,
  parameter int SETTLE_CYCLES = 8,
  parameter int SAMPLES       = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  evo_test_sequencer_if.slave bus
);
  localparam int NV = 1 << NUM_INPUTS;
  localparam int SW = (SETTLE_CYCLES > 2) ? $clog2(SETTLE_CYCLES) : 1;
  localparam int MW = (SAMPLES > 2) ? $clog2(SAMPLES) : 1;
  localparam logic [SW-1:0] SETTLE_LAST = SW'(SETTLE_CYCLES - 1);
  localparam logic [MW-1:0] SAMPLE_LAST = MW'(SAMPLES - 1);
  localparam logic [NUM_INPUTS:0] CNT_MAX = {1'b1, {NUM_INPUTS{1'b0}}};

  typedef enum logic [1:0] {
    S_IDLE,
    S_SETTLE,
    S_SAMPLE,
    S_DONE
  } state_t;

  state_t                state_q, state_d;
  logic [1:0]            sync_q;
  logic [NV-1:0]         exp_q, exp_d;
  logic [NUM_INPUTS-1:0] dut_in_q, dut_in_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic                  pass_q, pass_d;
  logic [NUM_INPUTS:0]   mism_q, mism_d;
  logic [NUM_INPUTS:0]   unst_q, unst_d;
  logic [NV-1:0]         result_q, result_d;
  logic [SW-1:0]         settle_cnt_q, settle_cnt_d;
  logic [MW-1:0]         sample_cnt_q, sample_cnt_d;
  logic                  first_q, first_d;
  logic                  all_eq_q, all_eq_d;
  logic                  sample;
  logic                  stable;

  // Only the second synchronizer stage is ever observed.
  assign sample = sync_q[1];

  function automatic logic [NUM_INPUTS:0] sat_inc(input logic [NUM_INPUTS:0] c);
    return (c == CNT_MAX) ? c : c + 1'b1;
  endfunction

  always_comb begin
    state_d      = state_q;
    exp_d        = exp_q;
    dut_in_d     = dut_in_q;
    done_d       = 1'b0;
    pass_d       = pass_q;
    mism_d       = mism_q;
    unst_d       = unst_q;
    result_d     = result_q;
    settle_cnt_d = settle_cnt_q;
    sample_cnt_d = sample_cnt_q;
    first_d      = first_q;
    all_eq_d     = all_eq_q;
    stable       = all_eq_q & (sample == first_q);

    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          exp_d        = bus.expected;
          mism_d       = '0;
          unst_d       = '0;
          result_d     = '0;
          pass_d       = 1'b0;
          dut_in_d     = '0;
          settle_cnt_d = '0;
          sample_cnt_d = '0;
          state_d      = S_SETTLE;
        end
      end

      S_SETTLE: begin
        if (bus.abort) begin
          state_d      = S_IDLE;
          dut_in_d     = '0;
          settle_cnt_d = '0;
        end else if (settle_cnt_q == SETTLE_LAST) begin
          settle_cnt_d = '0;
          sample_cnt_d = '0;
          state_d      = S_SAMPLE;
        end else begin
          settle_cnt_d = settle_cnt_q + 1'b1;
        end
      end

      S_SAMPLE: begin
        if (bus.abort) begin
          state_d      = S_IDLE;
          dut_in_d     = '0;
          sample_cnt_d = '0;
        end else begin
          if (sample_cnt_q == '0) begin
            first_d  = sample;
            all_eq_d = 1'b1;
          end else begin
            all_eq_d = stable;
          end

          if (sample_cnt_q == SAMPLE_LAST) begin
            result_d[dut_in_q] = sample;
            if (!stable) begin
              unst_d = sat_inc(unst_q);
              mism_d = sat_inc(mism_q);
            end else if (sample != exp_q[dut_in_q]) begin
              mism_d = sat_inc(mism_q);
            end
            sample_cnt_d = '0;
            // The last vector ends the run instead of wrapping dut_in.
            if (&dut_in_q) begin
              state_d = S_DONE;
              done_d  = 1'b1;
              pass_d  = (mism_d == '0);
            end else begin
              dut_in_d = dut_in_q + 1'b1;
              state_d  = S_SETTLE;
            end
          end else begin
            sample_cnt_d = sample_cnt_q + 1'b1;
          end
        end
      end

      S_DONE: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase

    busy_d = (state_d == S_SETTLE) || (state_d == S_SAMPLE);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      sync_q       <= '0;
      exp_q        <= '0;
      dut_in_q     <= '0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      pass_q       <= 1'b0;
      mism_q       <= '0;
      unst_q       <= '0;
      result_q     <= '0;
      settle_cnt_q <= '0;
      sample_cnt_q <= '0;
      first_q      <= 1'b0;
      all_eq_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      sync_q       <= {sync_q[0], bus.dut_out};
      exp_q        <= exp_d;
      dut_in_q     <= dut_in_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      pass_q       <= pass_d;
      mism_q       <= mism_d;
      unst_q       <= unst_d;
      result_q     <= result_d;
      settle_cnt_q <= settle_cnt_d;
      sample_cnt_q <= sample_cnt_d;
      first_q      <= first_d;
      all_eq_q     <= all_eq_d;
    end
  end

  assign bus.dut_in         = dut_in_q;
  assign bus.busy           = busy_q;
  assign bus.done           = done_q;
  assign bus.pass           = pass_q;
  assign bus.mismatch_count = mism_q;
  assign bus.unstable_count = unst_q;
  assign bus.result_vec     = result_q;
endmodule

// File: tb/tb_evo_test_sequencer.sv
// tb/tb_evo_test_sequencer.sv - directed scoreboard bench for evo_test_sequencer
module tb_evo_test_sequencer;
  localparam int N   = 5;
  localparam int S   = 8;
  localparam int M   = 4;
  localparam int VEC = S + M;
  localparam int RUN = (1 << N) * VEC;

  typedef struct {
    logic [31:0] rv;
    logic [31:0] mask;
    logic [5:0]  mm;
    logic [5:0]  un;
    logic        pass;
    int unsigned done_at;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  int unsigned cyc = 0;
  int unsigned done_seen = 0;
  logic        tgl = 1'b0;
  bit          toggle_mode = 1'b0;
  logic [31:0] model_tbl = 32'h6A3C_91F0;
  int          n_cmp = 0;
  int          n_err = 0;
  exp_t        sb[$];

  evo_test_sequencer_if #(.NUM_INPUTS(N)) bus ();

  evo_test_sequencer #(
    .NUM_INPUTS   (N),
    .SETTLE_CYCLES(S),
    .SAMPLES      (M)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    tgl <= ~tgl;
  end

  always @(negedge clk) if (bus.done) done_seen <= done_seen + 1;

  assign bus.dut_out = (toggle_mode && bus.dut_in == 5'd3) ? tgl : model_tbl[bus.dut_in];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic to_edge(input int unsigned k);
    while (cyc < k) @(negedge clk);
  endtask

  task automatic start_run(input logic [31:0] exp_tbl, input bit with_abort,
                           output int unsigned e0);
    bus.expected = exp_tbl;
    bus.start    = 1'b1;
    bus.abort    = with_abort;
    @(negedge clk);
    e0        = cyc;
    bus.start = 1'b0;
    bus.abort = 1'b0;
    chk("start_busy", 64'(bus.busy), 64'(1));
    chk("start_dut_in", 64'(bus.dut_in), 64'(0));
  endtask

  task automatic push_exp(input logic [31:0] rv, input logic [31:0] mask, input logic [5:0] mm,
                          input logic [5:0] un, input logic pass, input int unsigned done_at);
    exp_t e;
    e.rv = rv; e.mask = mask; e.mm = mm; e.un = un; e.pass = pass; e.done_at = done_at;
    sb.push_back(e);
  endtask

  task automatic wait_done();
    exp_t e;
    bit   got = 1'b0;
    for (int i = 0; i < RUN + 40 && !got; i++) begin
      @(negedge clk);
      if (bus.done) got = 1'b1;
    end
    e = sb.pop_front();
    if (!got) begin
      n_cmp++;
      n_err++;
      $error("FAIL done_timeout: observed no done, expected done at edge %0d", e.done_at);
    end else begin
      chk("done_edge", 64'(cyc), 64'(e.done_at));
      chk("result_vec", 64'(bus.result_vec & e.mask), 64'(e.rv & e.mask));
      chk("mismatch_count", 64'(bus.mismatch_count), 64'(e.mm));
      chk("unstable_count", 64'(bus.unstable_count), 64'(e.un));
      chk("pass", 64'(bus.pass), 64'(e.pass));
      chk("busy_at_done", 64'(bus.busy), 64'(0));
      @(negedge clk);
      chk("done_one_cycle", 64'(bus.done), 64'(0));
    end
  endtask

  task automatic chk_reset_vals(input string pfx);
    chk({pfx, "_dut_in"}, 64'(bus.dut_in), 64'(0));
    chk({pfx, "_busy"}, 64'(bus.busy), 64'(0));
    chk({pfx, "_done"}, 64'(bus.done), 64'(0));
    chk({pfx, "_pass"}, 64'(bus.pass), 64'(0));
    chk({pfx, "_mm"}, 64'(bus.mismatch_count), 64'(0));
    chk({pfx, "_un"}, 64'(bus.unstable_count), 64'(0));
    chk({pfx, "_rv"}, 64'(bus.result_vec), 64'(0));
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: observed run still active, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int unsigned e0;
    int unsigned seen;

    bus.start    = 1'b0;
    bus.abort    = 1'b0;
    bus.expected = '0;
    rst_n        = 1'b0;
    repeat (3) @(negedge clk);
    chk_reset_vals("reset");
    rst_n = 1'b1;
    @(negedge clk);

    // Matching expected table; abort high alongside start must be ignored in IDLE.
    start_run(model_tbl, 1'b1, e0);
    push_exp(model_tbl, 32'hFFFF_FFFF, 6'd0, 6'd0, 1'b1, e0 + RUN);
    to_edge(e0 + VEC - 1);
    chk("dut_in_before_step", 64'(bus.dut_in), 64'(0));
    to_edge(e0 + VEC);
    chk("dut_in_step", 64'(bus.dut_in), 64'(1));
    to_edge(e0 + 31 * VEC);
    chk("dut_in_last", 64'(bus.dut_in), 64'(31));
    chk("busy_last", 64'(bus.busy), 64'(1));
    wait_done();

    // One expected bit inverted.
    start_run(model_tbl ^ 32'h20, 1'b0, e0);
    push_exp(model_tbl, 32'hFFFF_FFFF, 6'd1, 6'd0, 1'b0, e0 + RUN);
    wait_done();

    // Oscillating output at vector 3; its captured bit is phase dependent.
    toggle_mode = 1'b1;
    start_run(model_tbl, 1'b0, e0);
    push_exp(model_tbl, 32'hFFFF_FFF7, 6'd1, 6'd1, 1'b0, e0 + RUN);
    wait_done();
    toggle_mode = 1'b0;

    // Expected changes after acceptance and a stray start mid-run.
    start_run(model_tbl, 1'b0, e0);
    bus.expected = '0;
    push_exp(model_tbl, 32'hFFFF_FFFF, 6'd0, 6'd0, 1'b1, e0 + RUN);
    to_edge(e0 + 99);
    bus.start = 1'b1;
    to_edge(e0 + 100);
    bus.start = 1'b0;
    wait_done();

    // Abort mid-run keeps partial counts.
    start_run(~model_tbl, 1'b0, e0);
    to_edge(e0 + 50);
    bus.abort = 1'b1;
    seen = done_seen;
    to_edge(e0 + 51);
    bus.abort = 1'b0;
    chk("abort_busy", 64'(bus.busy), 64'(0));
    chk("abort_dut_in", 64'(bus.dut_in), 64'(0));
    chk("abort_pass", 64'(bus.pass), 64'(0));
    chk("abort_mm", 64'(bus.mismatch_count), 64'(4));
    chk("abort_un", 64'(bus.unstable_count), 64'(0));
    chk("abort_rv", 64'(bus.result_vec), 64'(model_tbl & 32'hF));
    repeat (20) @(negedge clk);
    chk("abort_no_done", 64'(done_seen), 64'(seen));

    // Reset mid-run, then a clean full run.
    start_run(~model_tbl, 1'b0, e0);
    to_edge(e0 + 199);
    chk("pre_reset_mm", 64'(bus.mismatch_count), 64'(16));
    rst_n = 1'b0;
    seen  = done_seen;
    to_edge(e0 + 200);
    rst_n = 1'b1;
    chk_reset_vals("midrun_reset");
    repeat (20) @(negedge clk);
    chk("reset_no_done", 64'(done_seen), 64'(seen));
    chk("reset_idle_busy", 64'(bus.busy), 64'(0));

    start_run(model_tbl, 1'b0, e0);
    push_exp(model_tbl, 32'hFFFF_FFFF, 6'd0, 6'd0, 1'b1, e0 + RUN);
    wait_done();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/evo_test_sequencer.md
# evo_test_sequencer

Sequences exhaustive truth-table testing of one evolved N-input, single-output LCELL circuit. On `start` it drives every input vector 0…2^N−1 onto the circuit, waits a settle window, and samples the output over several cycles to catch oscillation from feedback loops. It then compares each sample against a latched expected truth table. It sits between the host/test controller and the circuit under test, and reports the captured truth table, mismatch and instability counts, and pass/fail.

## Interface
- `NUM_INPUTS`, 5, circuit input width N; vectors 0…2^N−1.
- `SETTLE_CYCLES`, 8, cycles after each vector change before sampling; legal range ≥2, covers the 2-flop synchronizer.
- `SAMPLES`, 4, consecutive sample cycles per vector; ≥2.

- `clk`, in, 1, single clock; every register updates on its rising edge.
- `rst_n`, in, 1, synchronous active-low reset, sampled on `clk`.
- `start`, in, 1, level; sampled only in IDLE.
- `abort`, in, 1, level; sampled in SETTLE/SAMPLE.
- `expected`, in, 2^N, expected output per vector (bit v = vector v); latched when `start` is accepted.
- `dut_in`, out, N, registered input vector driven to the circuit.
- `dut_out`, in, 1, circuit output; asynchronous, passed through a 2-flop synchronizer before any use.
- `busy`, out, 1, high in SETTLE/SAMPLE.
- `done`, out, 1, one-cycle pulse at completion.
- `pass`, out, 1, registered at completion: 1 iff `mismatch_count`==0.
- `mismatch_count`, out, N+1, vectors that are unstable or differ from expected.
- `unstable_count`, out, N+1, vectors whose samples were not all equal.
- `result_vec`, out, 2^N, captured output per vector.

## Operation
- States: IDLE, SETTLE, SAMPLE, DONE.
- Reset: state IDLE. `dut_in`=0, `busy`=0, `done`=0, `pass`=0, both counts=0, `result_vec`=0, sample and settle counters=0.
- IDLE, `start`=1: latch `expected`. Clear counts, `result_vec` and `pass`. `dut_in`←0, go to SETTLE.
- SETTLE: count SETTLE_CYCLES cycles, then go to SAMPLE. The synchronized output is ignored.
- SAMPLE: read the synchronized output on each of SAMPLES cycles. Track the first sample and an "all equal" flag.
- On the last sample cycle of vector v:
  - `result_vec[v]` ← final sample.
  - Unstable if not all equal → `unstable_count`+1 and `mismatch_count`+1.
  - Otherwise, if the sample ≠ latched `expected[v]` → `mismatch_count`+1.
  - If v<2^N−1: `dut_in`←v+1, return to SETTLE.
  - Else go to DONE.
- DONE: one cycle. `done`=1, `pass` registered, then IDLE.
- Counts saturate at 2^N (N+1 bits; they cannot overflow). `dut_in` never wraps mid-run; the run ends at the last vector.
- `start` in any state other than IDLE is ignored. `start` held high re-triggers a new run on the cycle after DONE returns to IDLE.
- `abort` in SETTLE/SAMPLE: go to IDLE next edge.
  - No `done` pulse, `pass` stays 0, `dut_in`←0.
  - Counts and `result_vec` keep their partial values.
- `abort` and `start` together in IDLE: `start` wins (`abort` is ignored in IDLE).
- `rst_n`=0 at any time, including mid-run: full reset values on that edge; no `done`.
- All outputs are registered.

## Timing
- Edge E0 samples `start`=1. From E0, `busy`=1 and `dut_in`=0.
- Each vector occupies exactly SETTLE_CYCLES+SAMPLES cycles.
- `dut_in` changes on edge E0 + k·(SETTLE_CYCLES+SAMPLES) for k=1…2^N−1.
- `done`=1 for exactly the one cycle after edge E0 + 2^N·(SETTLE_CYCLES+SAMPLES); `busy` drops on that same edge. With default parameters this is edge E0+384.
- Counts and `result_vec` update on the last-sample edge of each vector. Final values are valid when `done`=1 and are held until the next accepted `start`.
- The earliest next `start` is accepted one edge after the DONE cycle.
- Sample window for vector v: the last SAMPLES cycles before the next `dut_in` change. This includes the 2-cycle synchronizer delay, which is why SETTLE_CYCLES ≥2.

## Test plan
- Behavioural model of the 5-input circuit drives `dut_out`; `expected` = model truth table, e.g. 32'h6A3C_91F0. Required: `done` at E0+384, `result_vec`=32'h6A3C_91F0, `mismatch_count`=0, `unstable_count`=0, `pass`=1.
- Same model, `expected` with bit 5 inverted. Required: `mismatch_count`=1, `unstable_count`=0, `pass`=0; `result_vec` equals the model table.
- Model toggles `dut_out` every cycle while `dut_in`=3. Required: `unstable_count`=1, `mismatch_count`=1, `pass`=0.
- Change `expected` to 0 one cycle after `start` is accepted. Required: results are still compared against the latched value (same as scenario 1).
- Pulse `start` at E0+100 during a run. Required: ignored; `done` still at E0+384. `abort` at E0+50 → IDLE at E0+51, `busy`=0, `dut_in`=0, no `done`, `pass`=0.
- `rst_n`=0 for one cycle at E0+200. Required: all outputs at reset values on the next edge, no `done`. A new `start` then runs a full 384-cycle test correctly.
